// File: rtl/mem_port_arbiter.sv
// Serializes fetch, data-read and data-write requesters onto a single memory port,
// one outstanding transaction at a time, write > read > fetch with a fetch starvation guard.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] if_req_pc,
    input  logic                  if_req_en,
    output logic [ADDR_WIDTH-1:0] if_rsp_inst,
    output logic                  if_rsp_done,
    input  logic [ADDR_WIDTH-1:0] rd_req_addr,
    input  logic [1:0]            rd_req_size,
    input  logic                  rd_req_en,
    output logic [ADDR_WIDTH-1:0] rd_rsp_data,
    output logic                  rd_rsp_done,
    input  logic [ADDR_WIDTH-1:0] wr_req_addr,
    input  logic [1:0]            wr_req_size,
    input  logic [ADDR_WIDTH-1:0] wr_req_data,
    input  logic                  wr_req_en,
    output logic                  wr_rsp_done,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic [1:0]            mem_rd_size,
    output logic                  mem_rd_en,
    input  logic [ADDR_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_rd_done,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [1:0]            mem_wr_size,
    output logic [ADDR_WIDTH-1:0] mem_wr_data,
    output logic                  mem_wr_en,
    input  logic                  mem_wr_done
);

    // state | meaning
    // IDLE  | sample request enables, pick a winner, launch backend request
    // BUSY  | backend request held stable until the granted channel reports done
    // RESP  | one-cycle upstream done pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic [1:0] {GNT_FETCH, GNT_READ, GNT_WRITE} grant_t;

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    state_t           state;
    grant_t           grant;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             fetch_wins;

    always_comb begin
        cnt_inc    = (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1;
        fetch_wins = if_req_en && ((starve_cnt == STARVE_MAX) || (!wr_req_en && !rd_req_en));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= GNT_FETCH;
            starve_cnt  <= '0;
            if_rsp_inst <= '0;
            if_rsp_done <= 1'b0;
            rd_rsp_data <= '0;
            rd_rsp_done <= 1'b0;
            wr_rsp_done <= 1'b0;
            mem_rd_addr <= '0;
            mem_rd_size <= 2'd0;
            mem_rd_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_size <= 2'd0;
            mem_wr_data <= '0;
            mem_wr_en   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_wins) begin
                        // Fetches are always whole aligned words
                        grant       <= GNT_FETCH;
                        mem_rd_addr <= {if_req_pc[ADDR_WIDTH-1:2], 2'b00};
                        mem_rd_size <= 2'd2;
                        mem_rd_en   <= 1'b1;
                        starve_cnt  <= '0;
                        state       <= BUSY;
                    end else if (wr_req_en) begin
                        grant       <= GNT_WRITE;
                        mem_wr_addr <= wr_req_addr;
                        mem_wr_size <= wr_req_size;
                        mem_wr_data <= wr_req_data;
                        mem_wr_en   <= 1'b1;
                        starve_cnt  <= if_req_en ? cnt_inc : '0;
                        state       <= BUSY;
                    end else if (rd_req_en) begin
                        grant       <= GNT_READ;
                        mem_rd_addr <= rd_req_addr;
                        mem_rd_size <= rd_req_size;
                        mem_rd_en   <= 1'b1;
                        starve_cnt  <= if_req_en ? cnt_inc : '0;
                        state       <= BUSY;
                    end else begin
                        starve_cnt  <= '0;
                    end
                end
                BUSY: begin
                    if (grant == GNT_WRITE) begin
                        if (mem_wr_done) begin
                            mem_wr_en   <= 1'b0;
                            wr_rsp_done <= 1'b1;
                            state       <= RESP;
                        end
                    end else if (mem_rd_done) begin
                        mem_rd_en <= 1'b0;
                        state     <= RESP;
                        if (grant == GNT_READ) begin
                            rd_rsp_done <= 1'b1;
                            rd_rsp_data <= mem_rd_data;
                        end else begin
                            if_rsp_done <= 1'b1;
                            if_rsp_inst <= mem_rd_data;
                        end
                    end
                end
                RESP: begin
                    if_rsp_done <= 1'b0;
                    rd_rsp_done <= 1'b0;
                    wr_rsp_done <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vectors, hand sequences for
// reset/starvation/early-drop cases, and randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int G_NONE = 0, G_W = 1, G_R = 2, G_F = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_req_pc, if_rsp_inst, rd_req_addr, rd_rsp_data;
    logic [31:0] wr_req_addr, wr_req_data, mem_rd_addr, mem_rd_data;
    logic [31:0] mem_wr_addr, mem_wr_data;
    logic [1:0]  rd_req_size, wr_req_size, mem_rd_size, mem_wr_size;
    logic        if_req_en, if_rsp_done, rd_req_en, rd_rsp_done, wr_req_en, wr_rsp_done;
    logic        mem_rd_en, mem_rd_done, mem_wr_en, mem_wr_done;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_pc(if_req_pc), .if_req_en(if_req_en),
        .if_rsp_inst(if_rsp_inst), .if_rsp_done(if_rsp_done),
        .rd_req_addr(rd_req_addr), .rd_req_size(rd_req_size), .rd_req_en(rd_req_en),
        .rd_rsp_data(rd_rsp_data), .rd_rsp_done(rd_rsp_done),
        .wr_req_addr(wr_req_addr), .wr_req_size(wr_req_size), .wr_req_data(wr_req_data),
        .wr_req_en(wr_req_en), .wr_rsp_done(wr_rsp_done),
        .mem_rd_addr(mem_rd_addr), .mem_rd_size(mem_rd_size), .mem_rd_en(mem_rd_en),
        .mem_rd_data(mem_rd_data), .mem_rd_done(mem_rd_done),
        .mem_wr_addr(mem_wr_addr), .mem_wr_size(mem_wr_size), .mem_wr_data(mem_wr_data),
        .mem_wr_en(mem_wr_en), .mem_wr_done(mem_wr_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: consecutive data wins while fetch waits, plus last response per requester
    int          streak;
    logic [31:0] exp_rd_data, exp_if_inst;

    typedef struct {
        bit          w, r, f;
        logic [31:0] pc, raddr;
        logic [1:0]  rsize;
        logic [31:0] waddr;
        logic [1:0]  wsize;
        logic [31:0] wdata, rdata;
        int          delay;
        int          exp_g;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int predict();
        int g;
        if (if_req_en && streak >= STARVE_LIMIT) g = G_F;
        else if (wr_req_en)                      g = G_W;
        else if (rd_req_en)                      g = G_R;
        else if (if_req_en)                      g = G_F;
        else                                     g = G_NONE;
        if ((g == G_W || g == G_R) && if_req_en)
            streak = (streak < STARVE_LIMIT) ? streak + 1 : STARVE_LIMIT;
        else
            streak = 0;
        return g;
    endfunction

    function automatic logic [1:0] en_bits(input int g);
        return (g == G_W) ? 2'b10 : (g == G_NONE) ? 2'b00 : 2'b01;
    endfunction

    function automatic logic [2:0] done_bits(input int g);
        return (g == G_W) ? 3'b100 : (g == G_R) ? 3'b010 : (g == G_F) ? 3'b001 : 3'b000;
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        {wr_req_en, rd_req_en, if_req_en, mem_rd_done, mem_wr_done} = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n       = 1'b1;
        streak      = 0;
        exp_rd_data = '0;
        exp_if_inst = '0;
    endtask

    task automatic expect_grant(input int g);
        check("grant_en", 32'({mem_wr_en, mem_rd_en}), 32'(en_bits(g)));
        if (g == G_W) begin
            check("wr_addr", mem_wr_addr, wr_req_addr);
            check("wr_size", 32'(mem_wr_size), 32'(wr_req_size));
            check("wr_data", mem_wr_data, wr_req_data);
        end else if (g == G_R) begin
            check("rd_addr", mem_rd_addr, rd_req_addr);
            check("rd_size", 32'(mem_rd_size), 32'(rd_req_size));
        end else if (g == G_F) begin
            check("if_addr", mem_rd_addr, {if_req_pc[31:2], 2'b00});
            check("if_size", 32'(mem_rd_size), 32'd2);
        end
    endtask

    // Backend side: optional wait with spurious done on the other channel, then completion
    task automatic finish_txn(input int g, input int delay, input logic [31:0] rdata);
        for (int i = 0; i < delay; i++) begin
            mem_wr_done = (g != G_W) ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rd_done = (g == G_W) ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rd_data = $urandom;
            @(posedge clk);
            @(negedge clk);
            check("busy_hold", 32'({mem_wr_en, mem_rd_en}), 32'(en_bits(g)));
            check("busy_no_done", 32'({wr_rsp_done, rd_rsp_done, if_rsp_done}), 32'd0);
        end
        mem_wr_done = (g == G_W);
        mem_rd_done = (g != G_W);
        mem_rd_data = rdata;
        @(posedge clk);
        @(negedge clk);
        mem_wr_done = 1'b0;
        mem_rd_done = 1'b0;
        mem_rd_data = $urandom;
        if (g == G_R) exp_rd_data = rdata;
        if (g == G_F) exp_if_inst = rdata;
        check("resp_done", 32'({wr_rsp_done, rd_rsp_done, if_rsp_done}), 32'(done_bits(g)));
        check("resp_en_clear", 32'({mem_wr_en, mem_rd_en}), 32'd0);
        check("rd_rsp_data", rd_rsp_data, exp_rd_data);
        check("if_rsp_inst", if_rsp_inst, exp_if_inst);
        @(posedge clk);
        @(negedge clk);
        check("done_single", 32'({wr_rsp_done, rd_rsp_done, if_rsp_done}), 32'd0);
    endtask

    task automatic run_one(input int g, input int delay, input logic [31:0] rdata, input bit drop);
        @(posedge clk);
        @(negedge clk);
        expect_grant(g);
        if (drop) begin
            if (g == G_W) wr_req_en = 1'b0;
            if (g == G_R) rd_req_en = 1'b0;
            if (g == G_F) if_req_en = 1'b0;
        end
        finish_txn(g, delay, rdata);
    endtask

    initial begin
        vecs[0] = '{1, 0, 0, 32'h0, 32'h0, 2'd0, 32'h1000_0003, 2'd1, 32'h1234_5678, 32'h0, 0, G_W, 32'h1000_0003};
        vecs[1] = '{0, 1, 0, 32'h0, 32'h2000_0001, 2'd0, 32'h0, 2'd0, 32'h0, 32'h0000_00AB, 1, G_R, 32'h2000_0001};
        vecs[2] = '{0, 0, 1, 32'h0000_0FFF, 32'h0, 2'd0, 32'h0, 2'd0, 32'h0, 32'hCAFE_F00D, 2, G_F, 32'h0000_0FFC};
        vecs[3] = '{0, 1, 1, 32'h0000_0400, 32'h3000_0002, 2'd1, 32'h0, 2'd0, 32'h0, 32'h0000_BEEF, 0, G_R, 32'h3000_0002};
        vecs[4] = '{1, 1, 0, 32'h0, 32'h4000_0000, 2'd2, 32'h5000_0004, 2'd2, 32'hA5A5_5A5A, 32'h0, 3, G_W, 32'h5000_0004};
        vecs[5] = '{1, 0, 1, 32'h0000_0002, 32'h0, 2'd0, 32'h6000_0008, 2'd0, 32'h0000_0077, 32'h0, 1, G_W, 32'h6000_0008};

        // Reset with fetch requested and backend dones stuck high
        rst_n = 1'b0;
        {wr_req_en, rd_req_en} = '0;
        if_req_en = 1'b1;       if_req_pc = 32'h1000_0007;
        rd_req_addr = '0;       rd_req_size = '0;
        wr_req_addr = '0;       wr_req_size = '0;  wr_req_data = '0;
        mem_rd_done = 1'b1;     mem_wr_done = 1'b1; mem_rd_data = 32'hFFFF_FFFF;
        streak = 0; exp_rd_data = '0; exp_if_inst = '0;
        repeat (3) @(negedge clk);
        check("rst_en", 32'({mem_wr_en, mem_rd_en}), 32'd0);
        check("rst_done", 32'({wr_rsp_done, rd_rsp_done, if_rsp_done}), 32'd0);
        check("rst_rd_data", rd_rsp_data, 32'd0);
        check("rst_if_inst", if_rsp_inst, 32'd0);
        check("rst_mem_rd_addr", mem_rd_addr, 32'd0);
        check("rst_mem_wr", mem_wr_addr | mem_wr_data | 32'(mem_wr_size) | 32'(mem_rd_size), 32'd0);
        rst_n = 1'b1;
        mem_rd_done = 1'b0;
        mem_wr_done = 1'b0;
        void'(predict());
        run_one(G_F, 1, 32'h1111_2222, 0);
        if_req_en = 1'b0;

        // Fetch with a 3-cycle backend wait
        if_req_pc = 32'h0000_0106;
        if_req_en = 1'b1;
        void'(predict());
        run_one(G_F, 3, 32'h0050_0093, 0);
        if_req_en = 1'b0;

        // Directed vectors, each from a fresh reset
        foreach (vecs[i]) begin
            reset_dut();
            wr_req_en = vecs[i].w; rd_req_en = vecs[i].r; if_req_en = vecs[i].f;
            if_req_pc = vecs[i].pc; rd_req_addr = vecs[i].raddr; rd_req_size = vecs[i].rsize;
            wr_req_addr = vecs[i].waddr; wr_req_size = vecs[i].wsize; wr_req_data = vecs[i].wdata;
            void'(predict());
            @(posedge clk);
            @(negedge clk);
            expect_grant(vecs[i].exp_g);
            check("vec_addr", (vecs[i].exp_g == G_W) ? mem_wr_addr : mem_rd_addr, vecs[i].exp_addr);
            finish_txn(vecs[i].exp_g, vecs[i].delay, vecs[i].rdata);
            {wr_req_en, rd_req_en, if_req_en} = '0;
        end

        // All three at once: write, then read, then fetch
        reset_dut();
        wr_req_addr = 32'h8000_0010; wr_req_size = 2'd2; wr_req_data = 32'hDEAD_BEEF;
        rd_req_addr = 32'h8000_0020; rd_req_size = 2'd0;
        if_req_pc   = 32'h0000_0200;
        {wr_req_en, rd_req_en, if_req_en} = 3'b111;
        void'(predict()); run_one(G_W, 1, 32'h0, 0);           wr_req_en = 1'b0;
        void'(predict()); run_one(G_R, 2, 32'h0000_00A5, 0);   rd_req_en = 1'b0;
        void'(predict()); run_one(G_F, 0, 32'h0000_0013, 0);   if_req_en = 1'b0;

        // Write and fetch held continuously: W,W,W,W,F repeating
        reset_dut();
        wr_req_addr = 32'h9000_0000; wr_req_size = 2'd2; wr_req_data = 32'h0BAD_F00D;
        if_req_pc   = 32'h0000_0040;
        {wr_req_en, if_req_en} = 2'b11;
        for (int i = 0; i < 10; i++) begin
            void'(predict());
            run_one((i % 5 == 4) ? G_F : G_W, 0, $urandom, 0);
        end
        {wr_req_en, if_req_en} = 2'b00;

        // Read requester drops en while BUSY
        rd_req_addr = 32'h7000_0001; rd_req_size = 2'd1; rd_req_en = 1'b1;
        void'(predict());
        run_one(G_R, 2, 32'h0000_4321, 1);

        // Async reset in the middle of a write
        wr_req_addr = 32'hA000_0000; wr_req_size = 2'd2; wr_req_data = 32'h1357_9BDF;
        wr_req_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_wr_en", 32'(mem_wr_en), 32'd1);
        #2 rst_n = 1'b0;
        wr_req_en = 1'b0;
        #1;
        check("async_rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("async_rst_no_done", 32'(wr_rsp_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        streak = 0; exp_rd_data = '0; exp_if_inst = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("post_rst_idle", 32'({mem_wr_en, mem_rd_en, wr_rsp_done, rd_rsp_done, if_rsp_done}), 32'd0);
        end

        // Randomized traffic; a requester keeps its request until served
        for (int i = 0; i < 80; i++) begin
            int g;
            if (!wr_req_en && $urandom_range(0, 1) == 1) begin
                wr_req_en = 1'b1; wr_req_addr = $urandom;
                wr_req_size = 2'($urandom_range(0, 2)); wr_req_data = $urandom;
            end
            if (!rd_req_en && $urandom_range(0, 1) == 1) begin
                rd_req_en = 1'b1; rd_req_addr = $urandom;
                rd_req_size = 2'($urandom_range(0, 2));
            end
            if (!if_req_en && $urandom_range(0, 1) == 1) begin
                if_req_en = 1'b1; if_req_pc = $urandom;
            end
            g = predict();
            if (g == G_NONE) begin
                @(posedge clk);
                @(negedge clk);
                check("rand_idle", 32'({mem_wr_en, mem_rd_en}), 32'd0);
            end else begin
                run_one(g, int'($urandom_range(0, 3)), $urandom, 0);
                if (g == G_W) wr_req_en = 1'b0;
                if (g == G_R) rd_req_en = 1'b0;
                if (g == G_F) if_req_en = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
